// File: rtl/cpu_pkg.sv
// Opcodes, control FSM states and instruction field positions shared by the cpu_core_param slice.
package cpu_pkg;

  localparam int unsigned OpMsb  = 31;
  localparam int unsigned OpLsb  = 24;
  localparam int unsigned RegLsb = 16;
  localparam int unsigned ImmW   = 16;

  localparam logic [7:0] OpNop   = 8'h00;
  localparam logic [7:0] OpLdi   = 8'h01;
  localparam logic [7:0] OpMvac  = 8'h02;
  localparam logic [7:0] OpMvr   = 8'h03;
  localparam logic [7:0] OpLdar  = 8'h04;
  localparam logic [7:0] OpLoad  = 8'h05;
  localparam logic [7:0] OpStore = 8'h06;
  localparam logic [7:0] OpAdd   = 8'h07;
  localparam logic [7:0] OpSub   = 8'h08;
  localparam logic [7:0] OpInc   = 8'h09;
  localparam logic [7:0] OpDec   = 8'h0A;
  localparam logic [7:0] OpJmp   = 8'h0B;
  localparam logic [7:0] OpJz    = 8'h0C;
  localparam logic [7:0] OpMul   = 8'h0E;
  localparam logic [7:0] OpEnd   = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StHalt
  } cpu_state_e;

endpackage

// File: rtl/cpu_core_param_if.sv
// Instruction and data RAM req/ack bus of cpu_core_param; master = core, slave = memories.
interface cpu_core_param_if #(
  parameter int unsigned IADDR_W = 10,
  parameter int unsigned DADDR_W = 16,
  parameter int unsigned DMEM_DW = 8
);
  logic               imem_req;
  logic [IADDR_W-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_ack;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DMEM_DW-1:0] dmem_wdata;
  logic [DMEM_DW-1:0] dmem_rdata;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/cpu_regfile.sv
// General register file: one asynchronous read port, one synchronous write port, async clear.
module cpu_regfile #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata = regs_q[raddr];
endmodule

// File: rtl/cpu_core_param.sv
// Multi-cycle accumulator CPU core with req/ack instruction and data memory ports.
// Optional MUL instruction (opcode 0E) is enabled by defining CPU_MUL_EN.
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IADDR_W  = 10,
  parameter int unsigned DADDR_W  = 16,
  parameter int unsigned DMEM_DW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  cpu_core_param_if.master  bus,
  output logic [DATA_W-1:0] ac_out,
  output logic              z,
  output logic              finish,
  output logic              illegal
);
  localparam int unsigned RegW = $clog2(NUM_REGS);

  cpu_state_e         state_q;
  logic [IADDR_W-1:0] pc_q;
  logic [DADDR_W-1:0] ar_q;
  logic [31:0]        ir_q;
  logic [DATA_W-1:0]  ac_q;
  logic               z_q, finish_q, illegal_q;
  logic               imem_req_q, dmem_req_q, dmem_we_q;

  logic [7:0]         op;
  logic [RegW-1:0]    rsel;
  logic [ImmW-1:0]    imm;
  logic [DATA_W-1:0]  rdat, rf_wdata, alu_res;
  logic               rf_we, alu_wr, step;
  logic               unused_ir;

  assign op        = ir_q[OpMsb:OpLsb];
  assign rsel      = ir_q[RegLsb+RegW-1:RegLsb];
  assign imm       = ir_q[ImmW-1:0];
  assign unused_ir = ^ir_q[OpLsb-1:RegLsb+RegW];
  assign step      = (state_q == StExec) && enable;

  cpu_regfile #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W)
  ) u_regfile (
    .clk  (clk),
    .rst_n(reset),
    .raddr(rsel),
    .rdata(rdat),
    .we   (rf_we),
    .waddr(rsel),
    .wdata(rf_wdata)
  );

  // Single-cycle results; alu_wr marks ops that load AC and update z.
  always_comb begin
    alu_res  = ac_q;
    alu_wr   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = ac_q;
    case (op)
      OpLdi:  begin alu_res = DATA_W'(imm); alu_wr = 1'b1; end
      OpMvr:  begin alu_res = rdat;         alu_wr = 1'b1; end
      OpAdd:  begin alu_res = ac_q + rdat;  alu_wr = 1'b1; end
      OpSub:  begin alu_res = ac_q - rdat;  alu_wr = 1'b1; end
`ifdef CPU_MUL_EN
      OpMul:  begin alu_res = ac_q * rdat;  alu_wr = 1'b1; end
`endif
      OpMvac: rf_we = step;
      OpInc:  begin rf_we = step; rf_wdata = rdat + DATA_W'(1); end
      OpDec:  begin rf_we = step; rf_wdata = rdat - DATA_W'(1); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ar_q       <= '0;
      ir_q       <= '0;
      ac_q       <= '0;
      z_q        <= 1'b0;
      finish_q   <= 1'b0;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (enable) begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (imem_req_q && bus.imem_ack) begin
            ir_q       <= bus.imem_rdata;
            pc_q       <= pc_q + IADDR_W'(1);
            imem_req_q <= 1'b0;
            state_q    <= StExec;
          end else if (enable) begin
            imem_req_q <= 1'b1;
          end
        end
        StExec: if (enable) begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
          if (alu_wr) begin
            ac_q <= alu_res;
            z_q  <= (alu_res == '0);
          end
          case (op)
            OpNop, OpLdi, OpMvac, OpMvr, OpAdd, OpSub, OpInc, OpDec: ;
`ifdef CPU_MUL_EN
            OpMul: ;
`endif
            OpLdar: ar_q <= rdat[DADDR_W-1:0];
            OpJmp:  pc_q <= imm[IADDR_W-1:0];
            OpJz:   if (z_q) pc_q <= imm[IADDR_W-1:0];
            OpLoad, OpStore: begin
              state_q    <= StMem;
              imem_req_q <= 1'b0;
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (op == OpStore);
            end
            OpEnd: begin
              state_q    <= StHalt;
              imem_req_q <= 1'b0;
              finish_q   <= 1'b1;
            end
            default: begin
              state_q    <= StHalt;
              imem_req_q <= 1'b0;
              finish_q   <= 1'b1;
              illegal_q  <= 1'b1;
            end
          endcase
        end
        StMem: if (bus.dmem_ack) begin
          if (!dmem_we_q) begin
            ac_q <= DATA_W'(bus.dmem_rdata);
            z_q  <= (bus.dmem_rdata == '0);
          end
          dmem_req_q <= 1'b0;
          dmem_we_q  <= 1'b0;
          state_q    <= StFetch;
          imem_req_q <= enable;
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = ar_q;
  assign bus.dmem_wdata = ac_q[DMEM_DW-1:0];
  assign ac_out         = ac_q;
  assign z              = z_q;
  assign finish         = finish_q;
  assign illegal        = illegal_q;
endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: directed programs plus random programs checked against an ISA-level model.
module tb_cpu_core_param;
  localparam int unsigned IW = 10;
  localparam int unsigned AW = 16;
  localparam int unsigned MW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] ac_out;
  logic        z, finish, illegal;

  cpu_core_param_if #(.IADDR_W(IW), .DADDR_W(AW), .DMEM_DW(MW)) bus ();

  cpu_core_param #(
    .DATA_W(32), .NUM_REGS(8), .IADDR_W(IW), .DADDR_W(AW), .DMEM_DW(MW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .ac_out (ac_out),
    .z      (z),
    .finish (finish),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [1024];
  logic [7:0]  dmem [65536];
  logic [7:0]  m_dmem [65536];

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural reference state
  logic [9:0]  m_pc;
  logic [31:0] m_ac;
  logic        m_z, m_halted, m_illegal;
  logic [31:0] m_r [8];
  logic [15:0] m_ar;
  logic        m_dexp_valid, m_dexp_we;
  logic [15:0] m_dexp_addr;
  logic [7:0]  m_dexp_wdata;

  // Memory responder controls
  bit          en_rand = 0;
  int          iwait_fix = 0, dwait_fix = 0;
  int          iw_cnt = 0, iw_tgt = 0, dw_cnt = 0, dw_tgt = 0;
  int          dreq_cycles = 0;
  logic [9:0]  last_fetch, prev_fetch, wrap_addr;
  bit          prev_valid = 0, wrap_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input int r, input logic [15:0] imm);
    logic [2:0] rr;
    rr = 3'(r);
    return {op, 5'b0, rr, imm};
  endfunction

  task automatic model_exec(input logic [31:0] instr);
    logic [7:0]  op;
    logic [2:0]  r;
    logic [15:0] imm;
    op = instr[31:24];
    r = instr[18:16];
    imm = instr[15:0];
    m_pc = m_pc + 10'd1;
    case (op)
      8'h00: ;
      8'h01: begin m_ac = {16'h0, imm}; m_z = (m_ac == 0); end
      8'h02: m_r[r] = m_ac;
      8'h03: begin m_ac = m_r[r]; m_z = (m_ac == 0); end
      8'h04: m_ar = m_r[r][15:0];
      8'h05: begin
        m_dexp_valid = 1; m_dexp_addr = m_ar; m_dexp_we = 0;
        m_ac = {24'h0, m_dmem[m_ar]}; m_z = (m_ac == 0);
      end
      8'h06: begin
        m_dexp_valid = 1; m_dexp_addr = m_ar; m_dexp_we = 1; m_dexp_wdata = m_ac[7:0];
      end
      8'h07: begin m_ac = m_ac + m_r[r]; m_z = (m_ac == 0); end
      8'h08: begin m_ac = m_ac - m_r[r]; m_z = (m_ac == 0); end
      8'h09: m_r[r] = m_r[r] + 1;
      8'h0A: m_r[r] = m_r[r] - 1;
      8'h0B: m_pc = imm[9:0];
      8'h0C: if (m_z) m_pc = imm[9:0];
`ifdef CPU_MUL_EN
      8'h0E: begin m_ac = m_ac * m_r[r]; m_z = (m_ac == 0); end
`endif
      8'hFF: m_halted = 1;
      default: begin m_halted = 1; m_illegal = 1; end
    endcase
  endtask

  task automatic on_fetch(input logic [9:0] addr);
    check_eq("fetch_while_halted", m_halted, 0);
    check_eq("fetch_pc", addr, m_pc);
    check_eq("fetch_ac", ac_out, m_ac);
    check_eq("fetch_z", z, m_z);
    if (prev_valid && prev_fetch == 10'h3FF) begin
      wrap_seen = 1;
      wrap_addr = addr;
    end
    prev_fetch = addr;
    prev_valid = 1;
    last_fetch = addr;
    model_exec(imem[m_pc]);
  endtask

  task automatic on_data(input logic [15:0] addr, input logic we, input logic [7:0] wdata);
    check_eq("dmem_expected", m_dexp_valid, 1);
    check_eq("dmem_addr", addr, m_dexp_addr);
    check_eq("dmem_we", we, m_dexp_we);
    if (m_dexp_we) begin
      check_eq("dmem_wdata", wdata, m_dexp_wdata);
      m_dmem[m_dexp_addr] = m_dexp_wdata;
    end
    m_dexp_valid = 0;
  endtask

  // Memory responder and random enable driver; acks are decided on the falling edge.
  initial begin
    bus.imem_ack = 0; bus.imem_rdata = '0; bus.dmem_ack = 0; bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (en_rand) enable = ($urandom_range(0, 3) != 0);
      if (bus.imem_req === 1'b1) begin
        if (iw_cnt >= iw_tgt) begin
          bus.imem_ack = 1;
          bus.imem_rdata = imem[bus.imem_addr];
          on_fetch(bus.imem_addr);
        end else begin
          bus.imem_ack = 0;
          iw_cnt++;
        end
      end else begin
        bus.imem_ack = ($urandom_range(0, 7) == 0);
        bus.imem_rdata = $urandom();
        iw_cnt = 0;
        iw_tgt = (iwait_fix >= 0) ? iwait_fix : int'($urandom_range(0, 3));
      end
      if (bus.dmem_req === 1'b1) begin
        dreq_cycles++;
        if (dw_cnt >= dw_tgt) begin
          bus.dmem_ack = 1;
          if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
          else bus.dmem_rdata = dmem[bus.dmem_addr];
          on_data(bus.dmem_addr, bus.dmem_we, bus.dmem_wdata);
        end else begin
          bus.dmem_ack = 0;
          dw_cnt++;
        end
      end else begin
        bus.dmem_ack = ($urandom_range(0, 7) == 0);
        bus.dmem_rdata = 8'($urandom());
        dw_cnt = 0;
        dw_tgt = (dwait_fix >= 0) ? dwait_fix : int'($urandom_range(0, 3));
      end
    end
  end

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, {bus.imem_req, bus.dmem_req, bus.dmem_we, z, finish, illegal,
                             bus.imem_addr, bus.dmem_addr, bus.dmem_wdata}, 64'h0);
    check_eq({tag, "_ac"}, ac_out, 0);
  endtask

  // Reset the DUT, blank the program memory and the model.
  task automatic begin_test();
    en_rand = 0;
    enable = 0;
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    for (int i = 0; i < 1024; i++) imem[i] = 32'hFF00_0000;
    m_pc = '0; m_ac = '0; m_z = 0; m_halted = 0; m_illegal = 0; m_ar = '0;
    m_dexp_valid = 0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    dreq_cycles = 0; prev_valid = 0; wrap_seen = 0;
    iwait_fix = 0; dwait_fix = 0;
    reset = 1;
  endtask

  task automatic run_to_finish(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (finish !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_finish"}, finish, 1);
    check_eq({tag, "_model_halted"}, m_halted, 1);
    check_eq({tag, "_ac"}, ac_out, m_ac);
    check_eq({tag, "_z"}, z, m_z);
    check_eq({tag, "_illegal"}, illegal, m_illegal);
    check_eq({tag, "_dmem_pending"}, m_dexp_valid, 0);
    repeat (3) @(negedge clk);
    #1;
    check_eq({tag, "_halt_quiet"}, {bus.imem_req, bus.dmem_req, finish}, 3'b001);
  endtask

  task automatic gen_random_prog(input int len);
    logic [7:0]  op;
    logic [15:0] imm;
    logic [4:0]  junk;
    for (int i = 0; i < len - 1; i++) begin
      int k;
      k = int'($urandom_range(0, 39));
      if (k == 0) op = 8'($urandom_range(13, 254));
      else if (k == 1) op = 8'h0E;
      else op = 8'($urandom_range(0, 12));
      imm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom());
      if (op == 8'h0B || op == 8'h0C) imm = 16'($urandom_range(i + 1, len - 1));
      junk = 5'($urandom());
      imem[i] = {op, junk, 3'($urandom()), imm};
    end
    imem[len-1] = 32'hFF00_0000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dmem[i] = 8'($urandom());
      m_dmem[i] = dmem[i];
    end

    // 1: LDI/MVAC/ADD
    begin_test();
    imem[0] = ins(8'h01, 0, 16'd5); imem[1] = ins(8'h02, 1, 0); imem[2] = ins(8'h01, 0, 16'd3);
    imem[3] = ins(8'h07, 1, 0);     imem[4] = ins(8'hFF, 0, 0);
    enable = 1;
    run_to_finish("t1", 200);
    check_eq("t1_ac_8", ac_out, 32'd8);
    check_eq("t1_flags", {z, finish, illegal}, 3'b010);

    // 2: SUB to zero then JZ taken
    begin_test();
    imem[0] = ins(8'h01, 0, 16'd7); imem[1] = ins(8'h02, 2, 0); imem[2] = ins(8'h08, 2, 0);
    imem[3] = ins(8'h0C, 0, 16'h010); imem[4] = ins(8'h01, 0, 16'd9);
    imem[16] = ins(8'hFF, 0, 0);
    enable = 1;
    run_to_finish("t2", 200);
    check_eq("t2_z", z, 1);
    check_eq("t2_jz_target", last_fetch, 10'h010);

    // 3: LOAD with a late data ack
    begin_test();
    dmem[16'h1234] = 8'hA5; m_dmem[16'h1234] = 8'hA5;
    imem[0] = ins(8'h01, 0, 16'h1234); imem[1] = ins(8'h02, 3, 0); imem[2] = ins(8'h04, 3, 0);
    imem[3] = ins(8'h05, 0, 0);        imem[4] = ins(8'hFF, 0, 0);
    dwait_fix = 3;
    enable = 1;
    run_to_finish("t3", 200);
    check_eq("t3_dreq_cycles", dreq_cycles, 4);
    check_eq("t3_ac", ac_out, 32'h0000_00A5);

    // 4: PC wraps from 0x3FF to 0x000
    begin_test();
    imem[0] = ins(8'h03, 1, 0); imem[1] = ins(8'h0C, 0, 16'd3); imem[2] = ins(8'hFF, 0, 0);
    imem[3] = ins(8'h09, 1, 0); imem[4] = ins(8'h0B, 0, 16'h03FF);
    imem[10'h3FF] = ins(8'h00, 0, 0);
    enable = 1;
    run_to_finish("t4", 300);
    check_eq("t4_wrap_seen", wrap_seen, 1);
    check_eq("t4_wrap_addr", wrap_addr, 10'h000);

    // 5: opcode 0E
    begin_test();
    imem[0] = ins(8'h01, 0, 16'd7); imem[1] = ins(8'h02, 4, 0); imem[2] = ins(8'h01, 0, 16'd6);
    imem[3] = ins(8'h0E, 4, 0);     imem[4] = ins(8'hFF, 0, 0);
    enable = 1;
    run_to_finish("t5", 200);
`ifdef CPU_MUL_EN
    check_eq("t5_mul_ac", ac_out, 32'd42);
    check_eq("t5_mul_illegal", illegal, 0);
`else
    check_eq("t5_ill_ac", ac_out, 32'd6);
    check_eq("t5_ill_flags", {illegal, finish}, 2'b11);
`endif

    // 6a: stall in EXEC for 5 cycles
    begin_test();
    imem[0] = ins(8'h01, 0, 16'h55AA); imem[1] = ins(8'h02, 5, 0); imem[2] = ins(8'h09, 5, 0);
    imem[3] = ins(8'h03, 5, 0);        imem[4] = ins(8'hFF, 0, 0);
    enable = 1;
    begin
      int cyc;
      cyc = 0;
      do begin
        @(negedge clk);
        #1;
        cyc++;
      end while (!(bus.imem_req && bus.imem_ack) && cyc < 50);
      check_eq("t6_first_fetch", bus.imem_req && bus.imem_ack, 1);
    end
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq("t6_stall_state", {ac_out, bus.imem_req, bus.dmem_req, finish}, 35'h0);
    end
    enable = 1;
    run_to_finish("t6", 200);
    check_eq("t6_ac", ac_out, 32'h0000_55AB);

    // 6b: reset while a STORE waits for its ack
    begin_test();
    imem[0] = ins(8'h01, 0, 16'h0042); imem[1] = ins(8'h02, 1, 0); imem[2] = ins(8'h04, 1, 0);
    imem[3] = ins(8'h06, 0, 0);        imem[4] = ins(8'hFF, 0, 0);
    dwait_fix = 20;
    enable = 1;
    begin
      int cyc;
      cyc = 0;
      while (bus.dmem_req !== 1'b1 && cyc < 100) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check_eq("t6_mem_reached", bus.dmem_req, 1);
    end
    repeat (2) @(negedge clk);
    #1;
    reset = 0;
    #1;
    check_zero("t6_async_reset");

    // Random programs with random wait states and random enable
    for (int p = 0; p < 30; p++) begin
      begin_test();
      gen_random_prog(48);
      iwait_fix = -1;
      dwait_fix = -1;
      en_rand = 1;
      run_to_finish("rand", 5000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
